out_fifo_sc: RTL
================

Name: out_fifo_sc

Overview:
- Single-clock behavioural model of the PHY-side output FIFO; the write-side counterpart of the existing input FIFO.
- The fabric writes full 8-bit bytes per lane.
- The PHY side drains 4-bit nibbles per lane: two reads per entry in 4x8 mode, one read per entry in 4x4 mode.
- Used in simulation of the memory/PHY datapath in place of the vendor primitive.

Parameters:
- LANES, 10, number of independent byte lanes sharing one set of pointers/flags
- DEPTH, 8, entries; power of two, >= 4
- ALMOST_EMPTY_VALUE, 1, ALMOSTEMPTY threshold in entries (legal 1..2)
- ALMOST_FULL_VALUE, 1, ALMOSTFULL threshold in free entries (legal 1..2)
- ARRAY_MODE_4X8, 1, 1 = each entry read as low nibble then high nibble; 0 = 4x4, one read per entry, high nibble discarded

Ports:
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- WREN  in  1  write request
- D  in  LANES*8  write data; lane n = D[8n+7:8n]
- RDEN  in  1  read request
- Q  out  LANES*4  read data; lane n = Q[4n+3:4n]
- EMPTY  out  1  no unread nibble available
- ALMOSTEMPTY  out  1  entries held <= ALMOST_EMPTY_VALUE
- FULL  out  1  entries held == DEPTH
- ALMOSTFULL  out  1  DEPTH - entries held <= ALMOST_FULL_VALUE

Behaviour:
- State: wr_ptr and rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH); count (0..DEPTH); nib_phase (1 bit, used only when ARRAY_MODE_4X8=1); storage array DEPTH x LANES*8.
- Reset (RST_N low, asynchronous): pointers, count and nib_phase = 0; Q = 0; EMPTY = 1; ALMOSTEMPTY = 1; FULL = 0; ALMOSTFULL = 0. Storage contents are not reset.
- Release of reset is sampled synchronously. A WREN or RDEN high in the first edge after release is honoured.
- Write accepted when WREN=1 and FULL=0 (flag value before the edge): D stored at wr_ptr, wr_ptr+1.
- Write with FULL=1 is ignored; no state change.
- Read accepted when RDEN=1 and EMPTY=0. Q is registered, latency 1: Q after the edge = selected nibble of entry rd_ptr.
  - 4x8, nib_phase=0: low nibbles; nib_phase -> 1; entry not freed.
  - 4x8, nib_phase=1: high nibbles; nib_phase -> 0; rd_ptr+1; entry freed.
  - 4x4: low nibbles; rd_ptr+1; entry freed.
- Read with EMPTY=1 is ignored; Q holds its last value.
- count update: +1 on accepted write, -1 on entry free, unchanged if both occur in the same cycle.
- A partially read entry (nib_phase=1) still counts as held.
- Flags are registered and derived from next-state count each edge:
  - EMPTY = (count==0)
  - FULL = (count==DEPTH)
  - ALMOSTEMPTY = (count <= ALMOST_EMPTY_VALUE)
  - ALMOSTFULL = (DEPTH-count <= ALMOST_FULL_VALUE)
- Simultaneous events:
  - Write and read while FULL: read proceeds, write dropped.
  - Write and read while EMPTY: write stored, read ignored; EMPTY deasserts the next cycle.
  - Write and freeing read while neither full nor empty: count unchanged, both pointers advance.
- Reset mid-operation discards all content; the next read after reset is ignored until a write occurs.
- An illegal ALMOST_*_VALUE or non-power-of-two DEPTH triggers $display and $finish at time 0.

Optional Feature:
- Macro: OUT_FIFO_FWFT_EN.
- Defined (first-word fall-through): Q continuously presents the nibble selected by rd_ptr/nib_phase whenever EMPTY=0, visible the cycle after EMPTY falls. RDEN consumes the presented nibble, and Q advances at the same edge. Q = 0 after reset and holds its last value while EMPTY.
- Undefined: standard mode described above, latency 1 from RDEN.

Test Plan:
- Reset, then write lane0 D=8'hA5 (all lanes 8'hA5); RDEN two cycles -> Q lane0 = 4'h5 then 4'hA. EMPTY=1 after the 2nd read edge; ALMOSTEMPTY=1 throughout.
- 8 consecutive writes (0x10..0x17) -> FULL rises after 8th edge, ALMOSTFULL after 7th. 9th write 0xFF dropped. 16 reads return 0,1,1,1,...,7,1 (low, high) with no 0xF nibble.
- While FULL, WREN and RDEN high for 2 cycles -> 1st cycle: write dropped, nibble read. 2nd cycle: entry freed and write of that cycle also dropped, since FULL was still 1 before the edge. count returns to 7.
- ARRAY_MODE_4X8=0, write 8'h3C, 8'h96; read 2 -> Q = 4'hC, 4'h6; EMPTY=1 after 2 reads.
- Write 3 entries, read 1 nibble, assert RST_N=0 mid-cycle -> outputs immediately reset (Q=0, EMPTY=1). RDEN after release -> Q stays 0.
- OUT_FIFO_FWFT_EN defined: write 8'h5A -> Q lane0 = 4'hA one cycle after EMPTY falls, without RDEN. RDEN for one cycle -> Q = 4'h5.

Source files
------------

// File: rtl/out_fifo_sc_if.sv
// Handshake and data bundle between the fabric-side writer and the PHY-side
// nibble reader of out_fifo_sc.
interface out_fifo_sc_if #(
    parameter int LANES = 10
);
    logic                 WREN;
    logic [LANES*8-1:0]   D;
    logic                 RDEN;
    logic [LANES*4-1:0]   Q;
    logic                 EMPTY;
    logic                 ALMOSTEMPTY;
    logic                 FULL;
    logic                 ALMOSTFULL;

    modport master (
        output WREN, D, RDEN,
        input  Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
    );

    modport slave (
        input  WREN, D, RDEN,
        output Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
    );
endinterface

// File: rtl/out_fifo_sc.sv
// Single-clock PHY output FIFO: byte-wide writes per lane, nibble-wide reads.
// Define OUT_FIFO_FWFT_EN for first-word fall-through on Q.
module out_fifo_sc #(
    parameter int LANES              = 10,
    parameter int DEPTH              = 8,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1,
    parameter int ARRAY_MODE_4X8     = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    out_fifo_sc_if.slave  bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam bit MODE_4X8 = (ARRAY_MODE_4X8 != 0);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (ALMOST_EMPTY_VALUE < 1) || (ALMOST_EMPTY_VALUE > 2) ||
        (ALMOST_FULL_VALUE < 1) || (ALMOST_FULL_VALUE > 2)) begin : g_bad_param
        $fatal(1, "out_fifo_sc: illegal DEPTH or ALMOST_*_VALUE parameter");
    end

    logic [AW-1:0]      wr_ptr, wr_ptr_n;
    logic [AW-1:0]      rd_ptr, rd_ptr_n;
    logic [CW-1:0]      count, count_n;
    logic               nib_phase, nib_phase_n;
    logic [LANES*4-1:0] q_n;
    logic               wr_ok, rd_ok, rd_free;
    logic [LANES*8-1:0] mem [DEPTH];

    function automatic logic [LANES*4-1:0] sel_nib(input logic [LANES*8-1:0] entry,
                                                   input logic hi);
        logic [LANES*4-1:0] r;
        r = '0;
        for (int n = 0; n < LANES; n++)
            r[4*n +: 4] = hi ? entry[8*n+4 +: 4] : entry[8*n +: 4];
        return r;
    endfunction

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block can infer a latch.
    always_comb begin
        wr_ok       = bus.WREN && !bus.FULL;
        rd_ok       = bus.RDEN && !bus.EMPTY;
        // In 4x8 mode an entry is freed only once its high nibble has been read.
        rd_free     = rd_ok && (!MODE_4X8 || nib_phase);
        nib_phase_n = (MODE_4X8 && rd_ok) ? ~nib_phase : nib_phase;
        wr_ptr_n    = wr_ptr + AW'(wr_ok);
        rd_ptr_n    = rd_ptr + AW'(rd_free);
        count_n     = count;
        case ({wr_ok, rd_free})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

`ifdef OUT_FIFO_FWFT_EN
    logic [CW-1:0] remain;
    logic          hi_n;

    always_comb begin
        remain = count - CW'(rd_free);
        hi_n   = MODE_4X8 && nib_phase_n;
        q_n    = bus.Q;
        // Present the head after this edge; bypass D when the only held entry is the one being written.
        if (!bus.EMPTY) begin
            if (remain != '0)
                q_n = sel_nib(mem[rd_ptr_n], hi_n);
            else if (wr_ok)
                q_n = sel_nib(bus.D, 1'b0);
        end
    end
`else
    logic hi_sel;

    always_comb begin
        hi_sel = MODE_4X8 && nib_phase;
        q_n    = bus.Q;
        if (rd_ok)
            q_n = sel_nib(mem[rd_ptr], hi_sel);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            nib_phase       <= 1'b0;
            bus.Q           <= '0;
            bus.EMPTY       <= 1'b1;
            bus.ALMOSTEMPTY <= 1'b1;
            bus.FULL        <= 1'b0;
            bus.ALMOSTFULL  <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_n;
            rd_ptr          <= rd_ptr_n;
            count           <= count_n;
            nib_phase       <= nib_phase_n;
            bus.Q           <= q_n;
            bus.EMPTY       <= (count_n == '0);
            bus.FULL        <= (count_n == CW'(DEPTH));
            bus.ALMOSTEMPTY <= (int'(count_n) <= ALMOST_EMPTY_VALUE);
            bus.ALMOSTFULL  <= ((DEPTH - int'(count_n)) <= ALMOST_FULL_VALUE);
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // already make stale entries unreachable, and a reset-free array maps to RAM.
    always_ff @(posedge CLK) begin
        if (wr_ok)
            mem[wr_ptr] <= bus.D;
    end
endmodule
